// File: rtl/dcache_arb_pkg.sv
// Shared types for the dcache request arbiter: FSM states, store-queue entry
// layout and the load/store line-compare helper.
package dcache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STORE = 2'd1,
      LOAD  = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  bm;
   } sq_entry_t;

   // Store word address and load byte address fall in the same 128-byte line.
   function automatic logic same_line(input logic [29:0] st_addr, input logic [31:0] ld_addr);
      return st_addr[29:5] == ld_addr[31:7];
   endfunction

endpackage

// File: rtl/dcache_sq_fifo.sv
// Committed-store FIFO. The head entry stays resident until its cache write
// completes, and every slot address is exported for the load hazard compare.
module dcache_sq_fifo
   import dcache_arb_pkg::*;
#(
   parameter int SQ_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  sq_entry_t                  push_entry,
   input  logic                       pop,
   output sq_entry_t                  head,
   output logic                       full,
   output logic                       empty,
   output logic [SQ_DEPTH-1:0]        entry_valid,
   output logic [SQ_DEPTH-1:0][29:0]  entry_addr
);

   localparam int PTR_W = $clog2(SQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(SQ_DEPTH);

   sq_entry_t        mem [SQ_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_comb begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
         entry_addr[i] = mem[i].addr;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Push and pop never target the same slot: push is blocked when full, pop when empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (do_pop) begin
            rd_ptr              <= rd_ptr + PTR_W'(1);
            entry_valid[rd_ptr] <= 1'b0;
         end
         if (do_push) begin
            wr_ptr              <= wr_ptr + PTR_W'(1);
            entry_valid[wr_ptr] <= 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dcache_arbiter.sv
// Serialises buffered stores and the single load-miss slot onto the dcache
// request ports, one transaction at a time, with line-hazard and starvation control.
module dcache_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int SQ_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        cpu_clock_i,
   input  logic        cpu_reset_i,
   input  logic        st_valid_i,
   output logic        st_ready_o,
   input  logic [29:0] st_address_i,
   input  logic [31:0] st_data_i,
   input  logic [3:0]  st_bm_i,
   input  logic        ld_req_i,
   input  logic [31:0] ld_addr_i,
   input  logic [1:0]  ld_op_i,
   input  logic        ld_uncached_i,
   output logic        ld_ack_o,
   output logic [31:0] ld_data_o,
   output logic        sq_empty_o,
   output logic        store_valid_o,
   output logic [29:0] store_address_o,
   output logic [31:0] store_data_o,
   output logic [3:0]  store_bm_o,
   input  logic        cache_done_i,
   output logic        dc_req_o,
   output logic [31:0] dc_addr_o,
   output logic [1:0]  dc_op_o,
   output logic        dc_uncached_o,
   input  logic [31:0] dc_data_i,
   input  logic        dc_cmp_i
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   arb_state_t                state;
   logic [CNT_W-1:0]          starve_cnt;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      fifo_pop;
   logic                      hazard;
   logic                      force_store;
   logic                      load_ok;
   logic                      grant_store;
   logic                      grant_load;
   logic [SQ_DEPTH-1:0]       entry_valid;
   logic [SQ_DEPTH-1:0][29:0] entry_addr;
   sq_entry_t                 head;
   sq_entry_t                 push_entry;

   assign push_entry = '{addr: st_address_i, data: st_data_i, bm: st_bm_i};
   assign fifo_pop   = (state == STORE) & cache_done_i;
   assign st_ready_o = ~fifo_full;

   dcache_sq_fifo #(
      .SQ_DEPTH (SQ_DEPTH)
   ) u_sq (
      .clk         (cpu_clock_i),
      .reset       (cpu_reset_i),
      .push        (st_valid_i),
      .push_entry  (push_entry),
      .pop         (fifo_pop),
      .head        (head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .entry_valid (entry_valid),
      .entry_addr  (entry_addr)
   );

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
         hazard = hazard | (entry_valid[i] & same_line(entry_addr[i], ld_addr_i));
      end
   end

   // A full queue or an exhausted starvation budget outranks a pending load.
   assign force_store = fifo_full | ((starve_cnt == STARVE_MAX) & ~fifo_empty);
   assign load_ok     = ld_req_i & ~hazard;
   assign grant_store = force_store | (~load_ok & ~fifo_empty);
   assign grant_load  = load_ok & ~force_store;

   always_ff @(posedge cpu_clock_i) begin
      if (cpu_reset_i) begin
         state           <= IDLE;
         starve_cnt      <= '0;
         store_valid_o   <= 1'b0;
         store_address_o <= 30'h0;
         store_data_o    <= 32'h0;
         store_bm_o      <= 4'h0;
         dc_req_o        <= 1'b0;
         dc_addr_o       <= 32'h0;
         dc_op_o         <= 2'b00;
         dc_uncached_o   <= 1'b0;
         ld_ack_o        <= 1'b0;
         ld_data_o       <= 32'h0;
         sq_empty_o      <= 1'b1;
      end else begin
         ld_ack_o   <= 1'b0;
         sq_empty_o <= fifo_empty;
         case (state)
            IDLE: begin
               if (grant_store) begin
                  store_valid_o   <= 1'b1;
                  store_address_o <= head.addr;
                  store_data_o    <= head.data;
                  store_bm_o      <= head.bm;
                  starve_cnt      <= '0;
                  state           <= STORE;
               end else if (grant_load) begin
                  dc_req_o      <= 1'b1;
                  dc_addr_o     <= ld_addr_i;
                  dc_op_o       <= ld_op_i;
                  dc_uncached_o <= ld_uncached_i;
                  state         <= LOAD;
                  if (!fifo_empty && (starve_cnt != STARVE_MAX)) begin
                     starve_cnt <= starve_cnt + CNT_W'(1);
                  end
               end
            end
            STORE: begin
               if (cache_done_i) begin
                  store_valid_o <= 1'b0;
                  state         <= IDLE;
               end
            end
            LOAD: begin
               if (dc_cmp_i) begin
                  dc_req_o  <= 1'b0;
                  ld_data_o <= dc_data_i;
                  ld_ack_o  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               store_valid_o <= 1'b0;
               dc_req_o      <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dcache_arbiter.md
# dcache_arbiter

Sequences all traffic into the `dcache` request ports. It buffers committed stores in a small FIFO and owns the single load-miss request slot. Exactly one transaction is in flight at a time. It enforces store-to-line ordering for load misses and bounds store starvation. It sits between the load/store unit and `dcache`, and drives `store_*` and `dc_*` directly.

## Interface
- `SQ_DEPTH`, default 4: store FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, default 8: maximum consecutive load grants while the FIFO is non-empty.
- `cpu_clock_i`  in  1  clock.
- `cpu_reset_i`  in  1  reset. Synchronous and active-high; single clock domain.
- `st_valid_i` / `st_ready_o`  in/out  1  store enqueue handshake.
- `st_address_i`  in  30  word address.
- `st_data_i`  in  32  store data.
- `st_bm_i`  in  4  byte mask.
- `ld_req_i`  in  1  load-miss request; level, held until `ld_ack_o`.
- `ld_addr_i`  in  32  load address.
- `ld_op_i`  in  2  load size.
- `ld_uncached_i`  in  1  uncached load.
- `ld_ack_o`  out  1  one-cycle completion pulse.
- `ld_data_o`  out  32  captured read data.
- `sq_empty_o`  out  1  FIFO empty and no store in flight.
- `store_valid_o`, `store_address_o[29:0]`, `store_data_o[31:0]`, `store_bm_o[3:0]`  out  store request to the cache.
- `cache_done_i`  in  1  store complete.
- `dc_req_o`, `dc_addr_o[31:0]`, `dc_op_o[1:0]`, `dc_uncached_o`  out  load request to the cache.
- `dc_data_i`  in  32  cache read data.
- `dc_cmp_i`  in  1  load complete.

## Operation
- FSM states are `IDLE`, `STORE` and `LOAD`. All outputs are registered.
- Reset values:
  - FSM goes to `IDLE`; FIFO is emptied.
  - `store_valid_o`, `dc_req_o` and `ld_ack_o` are 0; `st_ready_o` is 1; `sq_empty_o` is 1.
  - All data/address outputs are 0; starvation counter is 0.
- Hazard: asserted when any FIFO entry has `address[29:5]` equal to `ld_addr_i[31:7]`. This is the same 128-byte line.
- Arbitration in `IDLE`, first match wins:
  1. FIFO full, or starvation counter equals `STARVE_LIMIT` with FIFO non-empty → grant the store.
  2. `ld_req_i` asserted and no hazard → grant the load.
  3. FIFO non-empty → grant the store.
- Store grant:
  - Load the head entry onto `store_*` and set `store_valid_o`.
  - Go to `STORE` and clear the starvation counter.
- Load grant:
  - Latch `ld_addr_i`, `ld_op_i` and `ld_uncached_i` onto `dc_*` and set `dc_req_o`.
  - Go to `LOAD`.
  - If the FIFO is non-empty, increment the starvation counter, saturating at `STARVE_LIMIT`.
- `STORE`:
  - `store_*` is held stable.
  - On `cache_done_i`: clear `store_valid_o`, pop the head, go to `IDLE`.
- `LOAD`:
  - `dc_*` is held stable.
  - On `dc_cmp_i`: clear `dc_req_o`, capture `dc_data_i` into `ld_data_o`, pulse `ld_ack_o`, go to `IDLE`.
- `cache_done_i` and `dc_cmp_i` are ignored in any state other than the one that issued the request.
- `store_valid_o` and `dc_req_o` are never both 1.
- Enqueue:
  - Occurs when `st_valid_i & st_ready_o`.
  - `st_ready_o` is derived from the registered count, so `st_ready_o = !full`.
  - When full, a same-cycle pop does not admit an enqueue.
- Simultaneous enqueue and pop leaves the count unchanged. Pointers wrap modulo `SQ_DEPTH`.
- Reset mid-operation: the in-flight request is dropped. Reset is only asserted while the cache is quiescent or also reset.

## Timing
- Grant occurs on the edge after the request is visible in `IDLE`. `store_valid_o` or `dc_req_o` rises 1 cycle after the request is sampled.
- A completion edge deasserts the request output on that same edge. The cache therefore sees the request low on its first cycle back in its idle state, which prevents re-issue.
- `ld_ack_o` and `ld_data_o` are valid in the cycle after `dc_cmp_i`.
- Back-to-back issue: `IDLE` costs 1 cycle between transactions.
- Minimum store turnaround is 3 cycles: grant, done, idle.
- `sq_empty_o` updates 1 cycle after the final pop.

## Structure
- Package `dcache_arb_pkg`:
  - FSM state enum.
  - Store entry struct `{addr[29:0], data[31:0], bm[3:0]}`.
- Sub-module `dcache_sq_fifo`:
  - `SQ_DEPTH`-entry synchronous FIFO with push, pop, full, empty.
  - Exposes all entry addresses in parallel for the hazard compare.
- FSM, arbitration and starvation counter live in `dcache_arbiter`.

## Test plan
- Single store at 0x100/0xDEADBEEF/0xF:
  - Expect `store_valid_o` to rise 1 cycle after enqueue.
  - Expect it to fall on the edge of `cache_done_i`.
  - Expect `sq_empty_o` = 1 afterwards.
- Load at 0x8000_0040, uncached, with empty FIFO:
  - Expect `dc_req_o` for exactly the duration until `dc_cmp_i`.
  - Expect `ld_data_o` = `dc_data_i` (0x1234_5678) with a 1-cycle `ld_ack_o`.
- Hazard: enqueue a store to word 0x20 (line 0x80), then a load to 0x84:
  - The store must issue first.
  - The load issues only after the pop.
- Fill 4 stores while a load is pending (no hazard):
  - Full FIFO forces a store grant.
  - `st_ready_o` = 0 while full, including on the cycle of a pop.
- Continuous loads with 1 queued store, `STARVE_LIMIT` = 8:
  - After 8 load grants, the next grant is the store.
  - Counter returns to 0 after the store grant.
- Assert reset during `LOAD`:
  - All outputs return to their reset values on the next edge.
  - A late `dc_cmp_i` produces no `ld_ack_o`.
